// File: rtl/combo_dial_checker_pkg.sv
// Package combo_pkg: shared constants for the combination dial checker.
//   - Direction codes produced by the quadrature encoder stage.
//   - FSM state encoding.
//   - req_dir(): required turning direction for each of the three numbers.
package combo_pkg;

  localparam logic [1:0] DIR_LEFT    = 2'b00;
  localparam logic [1:0] DIR_RIGHT   = 2'b01;
  localparam logic [1:0] DIR_ILLEGAL = 2'b10;
  localparam logic [1:0] DIR_HOLD    = 2'b11;

  typedef enum logic [2:0] {
    S_D0   = 3'd0,
    S_D1   = 3'd1,
    S_D2   = 3'd2,
    S_OPEN = 3'd3,
    S_FAIL = 3'd4
  } state_e;

  // Numbers are entered right-left-right.
  function automatic logic [1:0] req_dir(input logic [1:0] idx);
    logic [1:0] dir;
    case (idx)
      2'd0:    dir = DIR_RIGHT;
      2'd1:    dir = DIR_LEFT;
      2'd2:    dir = DIR_RIGHT;
      default: dir = DIR_HOLD;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/combo_dial_checker_dial_counter.sv
// dial_counter: modulo up/down dial position counter.
// Ports:
//   CLK        in  1      clock (rising edge)
//   RST        in  1      asynchronous reset, active-high
//   step       in  1      direction sample valid strobe
//   direction  in  2      01 = +1, 00 = -1, 11/10 = hold
//   position   out POS_W  registered position, 0..POS_MAX-1
// POS_W must equal $clog2(POS_MAX).
module dial_counter
  import combo_pkg::*;
#(
  parameter int POS_MAX = 16,
  parameter int POS_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             step,
  input  logic [1:0]       direction,
  output logic [POS_W-1:0] position
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX - 1);

  logic [POS_W-1:0] position_q, position_d;

  // Next position with wrap at both ends; illegal and hold codes keep the value.
  always_comb begin
    position_d = position_q;
    if (step && (direction == DIR_RIGHT)) begin
      position_d = (position_q == POS_TOP) ? {POS_W{1'b0}} : position_q + POS_W'(1);
    end else if (step && (direction == DIR_LEFT)) begin
      position_d = (position_q == {POS_W{1'b0}}) ? POS_TOP : position_q - POS_W'(1);
    end else begin
      position_d = position_q;
    end
  end

  // Position register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      position_q <= {POS_W{1'b0}};
    end else begin
      position_q <= position_d;
    end
  end

  assign position = position_q;

endmodule

// File: rtl/combo_dial_checker.sv
// combo_dial_checker: tracks the dial position and checks a right-left-right
// three-number combination against CODE0/1/2.
// Ports:
//   CLK         in  1      clock (rising edge)
//   RST         in  1      asynchronous reset, active-high
//   direction   in  2      01 right, 00 left, 11 hold, 10 illegal (hold)
//   step        in  1      direction sample valid
//   enter       in  1      submit current position as the next number
//   relock      in  1      abandon the attempt, back to S_D0
//   position    out POS_W  dial position
//   digit_idx   out 2      number expected next; 3 when open, 0 when failed
//   unlocked    out 1      state is S_OPEN
//   error       out 1      state is S_FAIL
//   locked_out  out 1      lockout active (always 0 unless COMBO_LOCKOUT_EN)
// Build option: define COMBO_LOCKOUT_EN to enable the fail counter and the
// timed lockout after MAX_FAILS consecutive failures.
module combo_dial_checker
  import combo_pkg::*;
#(
  parameter int POS_MAX        = 16,
  parameter int POS_W          = 4,
  parameter int CODE0          = 3,
  parameter int CODE1          = 12,
  parameter int CODE2          = 7,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       direction,
  input  logic             step,
  input  logic             enter,
  input  logic             relock,
  output logic [POS_W-1:0] position,
  output logic [1:0]       digit_idx,
  output logic             unlocked,
  output logic             error,
  output logic             locked_out
);

  state_e           state_q, state_d;
  logic [1:0]       last_dir_q, last_dir_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             unlocked_q, unlocked_d;
  logic             error_q, error_d;
  logic [POS_W-1:0] pos_s;
  logic             move_s;
  logic             relock_ok_s;
  logic             lock_active_s;
  logic             lock_expire_s;

  dial_counter #(
    .POS_MAX (POS_MAX),
    .POS_W   (POS_W)
  ) u_dial_counter (
    .CLK       (CLK),
    .RST       (RST),
    .step      (step),
    .direction (direction),
    .position  (pos_s)
  );

  assign move_s      = step && ((direction == DIR_RIGHT) || (direction == DIR_LEFT));
  assign relock_ok_s = relock && !lock_active_s;

  // Combination FSM next state; pos_s and last_dir_q are pre-edge values, so
  // a step in the same cycle as enter does not affect the comparison.
  always_comb begin
    state_d = state_q;
    if (lock_expire_s) begin
      state_d = S_D0;
    end else if (relock_ok_s) begin
      state_d = S_D0;
    end else if (enter) begin
      case (state_q)
        S_D0: state_d = ((pos_s == POS_W'(CODE0)) && (last_dir_q == req_dir(2'd0))) ? S_D1   : S_FAIL;
        S_D1: state_d = ((pos_s == POS_W'(CODE1)) && (last_dir_q == req_dir(2'd1))) ? S_D2   : S_FAIL;
        S_D2: state_d = ((pos_s == POS_W'(CODE2)) && (last_dir_q == req_dir(2'd2))) ? S_OPEN : S_FAIL;
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Last-direction tracker: any state change or relock forces fresh movement.
  always_comb begin
    last_dir_d = last_dir_q;
    if (relock_ok_s || (state_d != state_q)) begin
      last_dir_d = DIR_HOLD;
    end else if (move_s) begin
      last_dir_d = direction;
    end else begin
      last_dir_d = last_dir_q;
    end
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    unlocked_d = (state_d == S_OPEN);
    error_d    = (state_d == S_FAIL);
    case (state_d)
      S_D0:    digit_idx_d = 2'd0;
      S_D1:    digit_idx_d = 2'd1;
      S_D2:    digit_idx_d = 2'd2;
      S_OPEN:  digit_idx_d = 2'd3;
      default: digit_idx_d = 2'd0;
    endcase
  end

  // FSM, tracker and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_D0;
      last_dir_q  <= DIR_HOLD;
      digit_idx_q <= 2'd0;
      unlocked_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      digit_idx_q <= digit_idx_d;
      unlocked_q  <= unlocked_d;
      error_q     <= error_d;
    end
  end

`ifdef COMBO_LOCKOUT_EN
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int LCW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           fail_entry_s;
  logic           open_entry_s;

  assign fail_entry_s  = (state_d == S_FAIL) && (state_q != S_FAIL);
  assign open_entry_s  = (state_d == S_OPEN) && (state_q != S_OPEN);
  assign lock_active_s = locked_q;
  assign lock_expire_s = locked_q && (lock_cnt_q == {LCW{1'b0}});

  // Fail counting and lockout timer; the lockout lasts LOCKOUT_CYCLES cycles.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (locked_q) begin
      if (lock_cnt_q == {LCW{1'b0}}) begin
        locked_d   = 1'b0;
        fail_cnt_d = {FCW{1'b0}};
      end else begin
        lock_cnt_d = lock_cnt_q - LCW'(1);
      end
    end else if (fail_entry_s) begin
      if (fail_cnt_q == FCW'(MAX_FAILS - 1)) begin
        fail_cnt_d = FCW'(MAX_FAILS);
        locked_d   = 1'b1;
        lock_cnt_d = LCW'(LOCKOUT_CYCLES - 1);
      end else begin
        fail_cnt_d = fail_cnt_q + FCW'(1);
      end
    end else if (open_entry_s) begin
      fail_cnt_d = {FCW{1'b0}};
    end else begin
      fail_cnt_d = fail_cnt_q;
    end
  end

  // Lockout registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_cnt_q <= {FCW{1'b0}};
      lock_cnt_q <= {LCW{1'b0}};
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked_out = locked_q;
`else
  logic unused_cfg_s;

  assign unused_cfg_s  = (MAX_FAILS == 0) ^ (LOCKOUT_CYCLES == 0);
  assign lock_active_s = 1'b0;
  assign lock_expire_s = 1'b0;
  assign locked_out    = 1'b0;
`endif

  assign position  = pos_s;
  assign digit_idx = digit_idx_q;
  assign unlocked  = unlocked_q;
  assign error     = error_q;

endmodule
